// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the multi-channel clock gating controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON   = 2'b00,
        ST_WAKE = 2'b01,
        ST_OFF  = 2'b10
    } state_t;

    localparam int MAX_CH = 32;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/clock_gate_cell.sv
// Glitch-free clock gate: low-phase transparent latch followed by an AND.
module clock_gate_cell (
    input  logic clk_in,
    input  logic en,
    input  logic test_mode,
    output logic clk_out
);

    logic r_latch;

    // Enable is only captured while the clock is low, so clk_out passes whole high phases only.
    always_latch begin
        if (!clk_in) begin
            r_latch <= en | test_mode;
        end
    end

    assign clk_out = clk_in & r_latch;

endmodule

// File: rtl/multi_channel_clock_gate_ctrl.sv
// Per-channel idle detection, wake handshake and clock gating for NUM_CH channels.
module multi_channel_clock_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int CNT_W             = 8,
    parameter int WAKE_CYCLES       = 2,
    parameter int SYNC_STAGES       = 2,
    parameter int ENABLE_ACTIVE_LOW = 0
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [CNT_W-1:0]  idle_thresh,
    input  logic [NUM_CH-1:0] ch_busy,
    input  logic [NUM_CH-1:0] ch_wake_req,
    input  logic [NUM_CH-1:0] ch_force_on,
    input  logic              test_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_clk_en,
    output logic [NUM_CH-1:0] ch_ready,
    output logic              all_gated
);

    localparam int              WAKE_W    = clog2(WAKE_CYCLES);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_wakeS;
    logic [NUM_CH-1:0] w_idle;
    logic [NUM_CH-1:0] w_isOff;

    state_t            r_state      [NUM_CH];
    state_t            w_stateNxt   [NUM_CH];
    logic [CNT_W-1:0]  r_idleCnt    [NUM_CH];
    logic [CNT_W-1:0]  w_idleCntNxt [NUM_CH];
    logic [WAKE_W-1:0] r_wakeCnt    [NUM_CH];
    logic [WAKE_W-1:0] w_wakeCntNxt [NUM_CH];

    logic [NUM_CH-1:0] r_clkEn;
    logic [NUM_CH-1:0] r_ready;
    logic              r_allGated;

    assign w_busy = (ENABLE_ACTIVE_LOW != 0) ? ~ch_busy : ch_busy;
    assign w_idle = ~w_busy & ~w_wakeS & ~ch_force_on;

    generate
        if (SYNC_STAGES == 0) begin : g_noSync
            assign w_wakeS = ch_wake_req;
        end else begin : g_sync
            logic [NUM_CH-1:0] r_sync [SYNC_STAGES];

            // Multi-flop synchroniser for the asynchronous wake requests.
            always_ff @(posedge clk_in) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= '0;
                    end
                end else begin
                    r_sync[0] <= ch_wake_req;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end

            assign w_wakeS = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Next-state and counter logic for every channel; each channel is independent.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_stateNxt[i]   = r_state[i];
            w_idleCntNxt[i] = r_idleCnt[i];
            w_wakeCntNxt[i] = r_wakeCnt[i];
            unique case (r_state[i])
                ST_ON: begin
                    if (w_idle[i]) begin
                        if ((idle_thresh != '0) && (r_idleCnt[i] >= (idle_thresh - CNT_W'(1)))) begin
                            w_stateNxt[i] = ST_OFF;
                        end
                        if (r_idleCnt[i] != '1) begin
                            w_idleCntNxt[i] = r_idleCnt[i] + CNT_W'(1);
                        end
                    end else begin
                        w_idleCntNxt[i] = '0;
                    end
                end
                ST_OFF: begin
                    if (w_busy[i] || w_wakeS[i] || ch_force_on[i]) begin
                        w_stateNxt[i]   = ST_WAKE;
                        w_wakeCntNxt[i] = '0;
                    end
                end
                ST_WAKE: begin
                    if (r_wakeCnt[i] == WAKE_LAST) begin
                        w_stateNxt[i]   = ST_ON;
                        w_idleCntNxt[i] = '0;
                    end else begin
                        w_wakeCntNxt[i] = r_wakeCnt[i] + WAKE_W'(1);
                    end
                end
                default: begin
                    w_stateNxt[i] = ST_ON;
                end
            endcase
        end
    end

    // Decode of the current state used for the registered all-gated flag.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_isOff[i] = (r_state[i] == ST_OFF);
        end
    end

    // State, counters and registered outputs; enables are computed from next state so they align with it.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= ST_ON;
                r_idleCnt[i] <= '0;
                r_wakeCnt[i] <= '0;
            end
            r_clkEn    <= '1;
            r_ready    <= '1;
            r_allGated <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= w_stateNxt[i];
                r_idleCnt[i] <= w_idleCntNxt[i];
                r_wakeCnt[i] <= w_wakeCntNxt[i];
                r_clkEn[i]   <= (w_stateNxt[i] != ST_OFF);
                r_ready[i]   <= (w_stateNxt[i] == ST_ON);
            end
            r_allGated <= &w_isOff;
        end
    end

    assign ch_clk_en = r_clkEn;
    assign ch_ready  = r_ready;
    assign all_gated = r_allGated;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_gate
            clock_gate_cell u_gate (
                .clk_in    (clk_in),
                .en        (r_clkEn[g]),
                .test_mode (test_mode),
                .clk_out   (clk_out[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_clock_gate_ctrl.sv
// Directed scenario bench for the multi-channel clock gating controller.
module tb_multi_channel_clock_gate_ctrl;

    logic       clk_in;
    logic       rst;
    logic [7:0] idle_thresh;
    logic [3:0] ch_busy;
    logic [3:0] ch_wake_req;
    logic [3:0] ch_force_on;
    logic       test_mode;
    logic [3:0] clk_out;
    logic [3:0] ch_clk_en;
    logic [3:0] ch_ready;
    logic       all_gated;

    int total;
    int bad;

    multi_channel_clock_gate_ctrl #(
        .NUM_CH            (4),
        .CNT_W             (8),
        .WAKE_CYCLES       (2),
        .SYNC_STAGES       (2),
        .ENABLE_ACTIVE_LOW (0)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .idle_thresh (idle_thresh),
        .ch_busy     (ch_busy),
        .ch_wake_req (ch_wake_req),
        .ch_force_on (ch_force_on),
        .test_mode   (test_mode),
        .clk_out     (clk_out),
        .ch_clk_en   (ch_clk_en),
        .ch_ready    (ch_ready),
        .all_gated   (all_gated)
    );

    // Free-running source clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        idle_thresh = 8'd4;
        ch_busy     = '0;
        ch_wake_req = '0;
        ch_force_on = '0;
        test_mode   = 1'b0;
        step(2);
        total++;
        if (ch_clk_en !== 4'b1111) begin bad++; $display("[TB] FAIL reset_en got=%b want=%b", ch_clk_en, 4'b1111); end
        total++;
        if (ch_ready !== 4'b1111) begin bad++; $display("[TB] FAIL reset_ready got=%b want=%b", ch_ready, 4'b1111); end
        total++;
        if (all_gated !== 1'b0) begin bad++; $display("[TB] FAIL reset_allg got=%b want=%b", all_gated, 1'b0); end
        rst = 1'b0;
    endtask

    task automatic test_idle_gate();
        step(3);
        total++;
        if (ch_clk_en !== 4'b1111) begin bad++; $display("[TB] FAIL idle_early_en got=%b want=%b", ch_clk_en, 4'b1111); end
        step(1);
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL idle_gate_en got=%b want=%b", ch_clk_en, 4'b0000); end
        total++;
        if (ch_ready !== 4'b0000) begin bad++; $display("[TB] FAIL idle_gate_ready got=%b want=%b", ch_ready, 4'b0000); end
        total++;
        if (clk_out !== 4'b1111) begin bad++; $display("[TB] FAIL idle_last_phase got=%b want=%b", clk_out, 4'b1111); end
        total++;
        if (all_gated !== 1'b0) begin bad++; $display("[TB] FAIL idle_allg_early got=%b want=%b", all_gated, 1'b0); end
        step(1);
        total++;
        if (all_gated !== 1'b1) begin bad++; $display("[TB] FAIL idle_allg got=%b want=%b", all_gated, 1'b1); end
        total++;
        if (clk_out !== 4'b0000) begin bad++; $display("[TB] FAIL idle_clk_stopped got=%b want=%b", clk_out, 4'b0000); end
    endtask

    task automatic test_wake();
        ch_wake_req = 4'b0010;
        step(2);
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL wake_sync_en got=%b want=%b", ch_clk_en, 4'b0000); end
        step(1);
        ch_wake_req = 4'b0000;
        total++;
        if (ch_clk_en !== 4'b0010) begin bad++; $display("[TB] FAIL wake_en got=%b want=%b", ch_clk_en, 4'b0010); end
        total++;
        if (ch_ready !== 4'b0000) begin bad++; $display("[TB] FAIL wake_ready_early got=%b want=%b", ch_ready, 4'b0000); end
        step(1);
        total++;
        if (all_gated !== 1'b0) begin bad++; $display("[TB] FAIL wake_allg got=%b want=%b", all_gated, 1'b0); end
        total++;
        if (ch_ready !== 4'b0000) begin bad++; $display("[TB] FAIL wake_ready_mid got=%b want=%b", ch_ready, 4'b0000); end
        step(1);
        total++;
        if (ch_ready !== 4'b0010) begin bad++; $display("[TB] FAIL wake_ready got=%b want=%b", ch_ready, 4'b0010); end
        step(3);
        total++;
        if (ch_clk_en !== 4'b0010) begin bad++; $display("[TB] FAIL wake_idle_early got=%b want=%b", ch_clk_en, 4'b0010); end
        step(1);
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL wake_regate got=%b want=%b", ch_clk_en, 4'b0000); end
    endtask

    task automatic test_busy_restart();
        idle_thresh = 8'd5;
        ch_busy     = 4'b0100;
        step(3);
        total++;
        if (ch_ready !== 4'b0100) begin bad++; $display("[TB] FAIL busy_wake_ready got=%b want=%b", ch_ready, 4'b0100); end
        ch_busy = 4'b0000;
        step(3);
        ch_busy = 4'b0100;
        step(1);
        ch_busy = 4'b0000;
        step(4);
        total++;
        if (ch_clk_en !== 4'b0100) begin bad++; $display("[TB] FAIL busy_restart_en got=%b want=%b", ch_clk_en, 4'b0100); end
        step(1);
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL busy_gate_en got=%b want=%b", ch_clk_en, 4'b0000); end
    endtask

    task automatic test_force_on();
        idle_thresh = 8'd1;
        ch_force_on = 4'b1000;
        step(3);
        total++;
        if (ch_ready !== 4'b1000) begin bad++; $display("[TB] FAIL force_ready got=%b want=%b", ch_ready, 4'b1000); end
        step(20);
        total++;
        if (ch_clk_en !== 4'b1000) begin bad++; $display("[TB] FAIL force_hold_en got=%b want=%b", ch_clk_en, 4'b1000); end
        ch_force_on = 4'b0000;
        step(1);
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL force_release_en got=%b want=%b", ch_clk_en, 4'b0000); end
        step(1);
        total++;
        if (all_gated !== 1'b1) begin bad++; $display("[TB] FAIL force_allg got=%b want=%b", all_gated, 1'b1); end
    endtask

    task automatic test_bypass();
        test_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            #1;
            total++;
            if (clk_out !== 4'b0000) begin bad++; $display("[TB] FAIL bypass_low got=%b want=%b", clk_out, 4'b0000); end
            step(1);
            total++;
            if (clk_out !== 4'b1111) begin bad++; $display("[TB] FAIL bypass_high got=%b want=%b", clk_out, 4'b1111); end
        end
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL bypass_en got=%b want=%b", ch_clk_en, 4'b0000); end
        total++;
        if (all_gated !== 1'b1) begin bad++; $display("[TB] FAIL bypass_allg got=%b want=%b", all_gated, 1'b1); end
        test_mode = 1'b0;
        #1;
        total++;
        if (clk_out !== 4'b1111) begin bad++; $display("[TB] FAIL bypass_exit_glitch got=%b want=%b", clk_out, 4'b1111); end
        step(1);
        total++;
        if (clk_out !== 4'b0000) begin bad++; $display("[TB] FAIL bypass_exit_gated got=%b want=%b", clk_out, 4'b0000); end
    endtask

    task automatic test_reset_in_wake();
        idle_thresh = 8'd4;
        ch_busy     = 4'b0001;
        step(1);
        total++;
        if (ch_clk_en !== 4'b0001) begin bad++; $display("[TB] FAIL rstw_enter_en got=%b want=%b", ch_clk_en, 4'b0001); end
        step(1);
        ch_busy = 4'b0000;
        rst     = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if (ch_clk_en !== 4'b1111) begin bad++; $display("[TB] FAIL rstw_en got=%b want=%b", ch_clk_en, 4'b1111); end
        total++;
        if (ch_ready !== 4'b1111) begin bad++; $display("[TB] FAIL rstw_ready got=%b want=%b", ch_ready, 4'b1111); end
        total++;
        if (all_gated !== 1'b0) begin bad++; $display("[TB] FAIL rstw_allg got=%b want=%b", all_gated, 1'b0); end
        step(3);
        total++;
        if (ch_clk_en !== 4'b1111) begin bad++; $display("[TB] FAIL rstw_count_en got=%b want=%b", ch_clk_en, 4'b1111); end
        step(1);
        total++;
        if (ch_clk_en !== 4'b0000) begin bad++; $display("[TB] FAIL rstw_gate_en got=%b want=%b", ch_clk_en, 4'b0000); end
    endtask

    // Scenario sequence; every task leaves the channels in a known state for the next.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_idle_gate();
        test_wake();
        test_busy_restart();
        test_force_on();
        test_bypass();
        test_reset_in_wake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
